// File: rtl/piezo_tone_decoder_if.sv
// Tone path bundle: square wave into the decoder and the decoded note coming back.
interface piezo_tone_decoder_if;
    logic       tone_in;
    logic [3:0] mode;
    logic       valid;
    logic       note_change;

    modport master (output tone_in, input mode, valid, note_change);
    modport slave  (input tone_in, output mode, valid, note_change);
endinterface

// File: rtl/piezo_tone_decoder.sv
// Square-wave half-period meter that matches against the 8-note table and
// reports a debounced note code (0 = silence/unknown).
module piezo_tone_decoder #(
    parameter int TOL       = 8,
    parameter int MATCH_CNT = 3,
    parameter int TIMEOUT   = 4000
) (
    input  logic                 clk_1MHz,
    input  logic                 rst,
    piezo_tone_decoder_if.slave  tone
);
    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

    localparam logic [12:0] TOL_W     = 13'(TOL);
    localparam logic [11:0] TIMEOUT_W = 12'(TIMEOUT);
    localparam logic [2:0]  MATCH_W   = 3'(MATCH_CNT);

    function automatic logic [12:0] nom(input int k);
        case (k)
            1:       nom = 13'd1912;
            2:       nom = 13'd1704;
            3:       nom = 13'd1518;
            4:       nom = 13'd1433;
            5:       nom = 13'd1276;
            6:       nom = 13'd1137;
            7:       nom = 13'd1013;
            default: nom = 13'd957;
        endcase
    endfunction

    logic        sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [11:0] hp_cnt_q, hp_cnt_d;
    logic [2:0]  run_q, run_d;
    logic [3:0]  run_code_q, run_code_d;
    state_t      state_q, state_d;
    logic [3:0]  mode_q, mode_d;
    logic        valid_q, valid_d;
    logic        note_change_q, note_change_d;

    logic        tone_edge;
    logic [12:0] hp;
    logic [3:0]  code;

    assign tone_edge = sync2_q ^ prev_q;
    // hp is one more than the count, since the count is cleared on the edge cycle itself
    assign hp = {1'b0, hp_cnt_q} + 13'd1;

    always_comb begin
        code = 4'd0;
        for (int k = 1; k <= 8; k++)
            if ((hp + TOL_W >= nom(k)) && (hp <= nom(k) + TOL_W))
                code = 4'(k);
    end

    always_comb begin
        sync1_d    = tone.tone_in;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        hp_cnt_d   = hp_cnt_q;
        run_d      = run_q;
        run_code_d = run_code_q;
        state_d    = state_q;
        mode_d     = mode_q;

        if (tone_edge)
            hp_cnt_d = 12'd0;
        else if (hp_cnt_q != TIMEOUT_W)
            hp_cnt_d = hp_cnt_q + 12'd1;

        if (tone_edge) begin
            if (code == 4'd0)
                run_d = 3'd0;
            else if (code == run_code_q)
                run_d = (run_q >= MATCH_W) ? MATCH_W : run_q + 3'd1;
            else begin
                run_d      = 3'd1;
                run_code_d = code;
            end

            // A pending note change while LOCKED keeps the old mode until it qualifies
            if (code == 4'd0) begin
                state_d = IDLE;
                mode_d  = 4'd0;
            end else if (run_d == MATCH_W) begin
                state_d = LOCKED;
                mode_d  = run_code_d;
            end else if (state_q == IDLE) begin
                state_d = ACQUIRE;
            end
        end else if (hp_cnt_q == TIMEOUT_W) begin
            state_d = IDLE;
            mode_d  = 4'd0;
            run_d   = 3'd0;
        end

        valid_d       = (mode_d != 4'd0);
        note_change_d = (mode_d != mode_q);
    end

    always_ff @(posedge clk_1MHz or posedge rst) begin
        if (rst) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            prev_q        <= 1'b0;
            hp_cnt_q      <= 12'd0;
            run_q         <= 3'd0;
            run_code_q    <= 4'd0;
            state_q       <= IDLE;
            mode_q        <= 4'd0;
            valid_q       <= 1'b0;
            note_change_q <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            prev_q        <= prev_d;
            hp_cnt_q      <= hp_cnt_d;
            run_q         <= run_d;
            run_code_q    <= run_code_d;
            state_q       <= state_d;
            mode_q        <= mode_d;
            valid_q       <= valid_d;
            note_change_q <= note_change_d;
        end
    end

    assign tone.mode        = mode_q;
    assign tone.valid       = valid_q;
    assign tone.note_change = note_change_q;
endmodule

// File: tb/tb_piezo_tone_decoder.sv
// Randomized half-period stimulus; a note-history model feeds a scoreboard of
// (mode, cycle) changes that a negedge monitor checks against the decoder.
module tb_piezo_tone_decoder;
    localparam int TOL       = 8;
    localparam int MATCH_CNT = 3;
    localparam int TIMEOUT   = 4000;

    logic clk_1MHz = 1'b0;
    logic rst      = 1'b1;
    piezo_tone_decoder_if tif();

    piezo_tone_decoder #(.TOL(TOL), .MATCH_CNT(MATCH_CNT), .TIMEOUT(TIMEOUT)) dut (
        .clk_1MHz (clk_1MHz),
        .rst      (rst),
        .tone     (tif)
    );

    always #5 clk_1MHz = ~clk_1MHz;

    int cyc = 0;
    always @(posedge clk_1MHz) cyc <= cyc + 1;

    typedef struct { logic [3:0] mode; int cyc; } exp_t;
    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    int   noms[9] = '{0, 1912, 1704, 1518, 1433, 1276, 1137, 1013, 957};
    int   hist[$];
    logic [3:0] m_mode = 4'd0;
    bit   have_last = 1'b0;
    bit   timed_out = 1'b0;
    int   t_last = 0;

    function automatic int code_of(input int hp);
        for (int k = 1; k <= 8; k++) begin
            int d;
            d = hp - noms[k];
            if (d < 0) d = -d;
            if (d <= TOL) return k;
        end
        return 0;
    endfunction

    // Mode follows the last MATCH_CNT samples when they agree; any bad sample clears to 0.
    task automatic model_sample(input int hp, input int t);
        int c;
        logic [3:0] nm;
        c  = code_of(hp);
        nm = m_mode;
        if (c == 0) begin
            hist.delete();
            nm = 4'd0;
        end else begin
            hist.push_back(c);
            if (hist.size() >= MATCH_CNT) begin
                bit same;
                same = 1'b1;
                for (int i = hist.size() - MATCH_CNT; i < hist.size(); i++)
                    if (hist[i] != c) same = 1'b0;
                if (same) nm = 4'(c);
            end
        end
        if (nm != m_mode) q.push_back('{nm, t});
        m_mode = nm;
    endtask

    task automatic timeout_evt();
        hist.delete();
        if (m_mode != 4'd0) q.push_back('{4'd0, t_last + TIMEOUT + 4});
        m_mode    = 4'd0;
        timed_out = 1'b1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_1MHz);
        #1;
    endtask

    task automatic tog(input int n);
        int c, hp;
        c = cyc + n;
        if (have_last && !timed_out && (c - t_last >= TIMEOUT + 2)) timeout_evt();
        if (!have_last) hp = 0;
        else hp = (c - t_last > TIMEOUT + 1) ? TIMEOUT + 1 : c - t_last;
        model_sample(hp, c + 3);
        have_last = 1'b1;
        timed_out = 1'b0;
        t_last    = c;
        wait_cyc(n);
        tif.tone_in = ~tif.tone_in;
    endtask

    task automatic quiet(input int n);
        if (have_last && !timed_out && (cyc + n - t_last >= TIMEOUT + 1)) timeout_evt();
        wait_cyc(n);
    endtask

    function automatic int jit(input int span);
        return int'($urandom_range(0, 2 * span)) - span;
    endfunction

    task automatic check_empty(input string name);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL %s: %0d expected changes still pending, want 0 (next mode=%0d cyc=%0d)",
                     name, q.size(), q[0].mode, q[0].cyc);
        end
    endtask

    task automatic mid_reset(input int hold);
        check_empty("pending_before_reset");
        rst = 1'b1;
        #1;
        tests++;
        if (tif.mode !== 4'd0 || tif.valid !== 1'b0 || tif.note_change !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: mode=%0d valid=%0d nc=%0d, want all 0",
                     tif.mode, tif.valid, tif.note_change);
        end
        hist.delete();
        m_mode    = 4'd0;
        have_last = 1'b0;
        timed_out = 1'b0;
        wait_cyc(hold);
        rst = 1'b0;
    endtask

    exp_t e;
    logic [3:0] prev_mode = 4'd0;
    always @(negedge clk_1MHz) begin
        if (rst) begin
            tests++;
            if (tif.mode !== 4'd0 || tif.valid !== 1'b0 || tif.note_change !== 1'b0) begin
                fails++;
                $display("FAIL rst_outputs: mode=%0d valid=%0d nc=%0d at cyc %0d, want all 0",
                         tif.mode, tif.valid, tif.note_change, cyc);
            end
            prev_mode = 4'd0;
        end else if (tif.note_change !== 1'b0 || tif.mode !== prev_mode) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_change: mode %0d->%0d nc=%0d at cyc %0d, want no change",
                         prev_mode, tif.mode, tif.note_change, cyc);
            end else begin
                e = q.pop_front();
                if (tif.mode !== e.mode || tif.valid !== (e.mode != 4'd0) ||
                    tif.note_change !== 1'b1 || cyc != e.cyc) begin
                    fails++;
                    $display("FAIL sb_change: got mode=%0d valid=%0d nc=%0d cyc=%0d, want mode=%0d valid=%0d nc=1 cyc=%0d",
                             tif.mode, tif.valid, tif.note_change, cyc, e.mode, e.mode != 4'd0, e.cyc);
                end
            end
            prev_mode = tif.mode;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tif.tone_in = 1'b0;
        rst = 1'b1;
        // reset held while the input chatters
        repeat (20) begin
            @(posedge clk_1MHz);
            #1;
            tif.tone_in = 1'($urandom_range(0, 1));
        end
        rst = 1'b0;
        quiet($urandom_range(100, 300));

        // A4 with jitter: locks on the 4th edge, then holds
        repeat (12) tog(1137 + jit(TOL));

        // C5 tolerance edges: +8 locks, +9 drops and never locks, -8 locks, -9 drops
        repeat (4) tog(965);
        repeat (3) tog(966);
        repeat (4) tog(949);
        tog(948);

        // C4 lock then direct switch to E4
        repeat (4) tog(1912 + jit(TOL));
        repeat (4) tog(1518 + jit(TOL));

        // G4, silence timeout, relock, single glitch half-period
        repeat (4) tog(1276);
        quiet(TIMEOUT + 50);
        repeat (5) tog(1276 + jit(TOL));
        tog(1400);

        // B4 lock, async reset, reacquire
        repeat (4) tog(1013);
        mid_reset(5);
        quiet($urandom_range(100, 300));
        repeat (5) tog(1013 + jit(TOL));

        // random note bursts, sometimes just outside tolerance
        repeat (3) begin
            int k, len;
            k   = $urandom_range(1, 8);
            len = $urandom_range(1, 3);
            repeat (len) tog(noms[k] + jit(TOL + 2));
        end

        quiet(TIMEOUT + 20);
        wait_cyc(10);
        check_empty("pending_at_end");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
